// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the byte-enabled dual-port RAM.
package ram_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {CLEAR, READY} state_e;
endpackage

// File: rtl/ram_be_dp_if.sv
// Write/read port bundle for ram_be_dp; master drives requests, slave returns data.
interface ram_be_dp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYTE_WIDTH = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] data;
    logic [NUM_BYTES-1:0]  be;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  re;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  init_busy;

    modport master (
        output data, be, write_addr, we, read_addr, re,
        input  q, q_valid, init_busy
    );
    modport slave (
        input  data, be, write_addr, we, read_addr, re,
        output q, q_valid, init_busy
    );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sweep: walks every word once, then hands the RAM to the user ports.
import ram_pkg::*;

module ram_clear_seq #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_busy
);
    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we) cnt <= cnt + 1'b1;
        end
    end

    // Counter wraps back to 0 on the last word, so it is ready for the next sweep.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (&cnt) state_nxt = READY;
            end
            default: ;
        endcase
    end

    assign clr_addr  = cnt;
    assign init_busy = (state == CLEAR);
endmodule

// File: rtl/ram_be_dp.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write,
// optional output register and a deterministic clear sweep after reset.
import ram_pkg::*;

module ram_be_dp #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   ADDR_WIDTH = 3,
    parameter int                   BYTE_WIDTH = 8,
    parameter int                   RDW_MODE   = RDW_OLD,
    parameter int                   OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic      clk,
    input logic      rst,
    ram_be_dp_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int STAGES    = (OUT_REG != 0) ? 1 : 0;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_be_dp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] word_t;

    word_t                 mem [DEPTH];
    logic                  clr_we, busy;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  user_we, user_re;
    word_t                 wdata, rd_old, rd_byp, rd_reg;
    logic [STAGES:0]       vld_pipe;

    ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (busy)
    );

    assign bus.init_busy = busy;
    assign user_we = bus.we & ~busy & ~rst;
    assign user_re = bus.re & ~busy & ~rst;
    assign wdata   = bus.data;
    assign rd_old  = mem[bus.read_addr];

    always_comb begin
        rd_byp = rd_old;
        if (RDW_MODE == RDW_NEW && user_we && bus.write_addr == bus.read_addr) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (bus.be[i]) rd_byp[i] = wdata[i];
        end
    end

    // Sweep owns the write port while busy; user writes are gated off above.
    always_ff @(posedge clk) begin
        if (clr_we && !rst) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (user_we) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (bus.be[i]) mem[bus.write_addr][i] <= wdata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_reg   <= '0;
        end else begin
            vld_pipe[0] <= user_re;
            for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
            if (user_re) rd_reg <= rd_byp;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        word_t q_reg;
        always_ff @(posedge clk) begin
            if (rst)              q_reg <= '0;
            else if (vld_pipe[0]) q_reg <= rd_reg;
        end
        assign bus.q = q_reg;
    end else begin : g_noreg
        assign bus.q = rd_reg;
    end

    assign bus.q_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_ram_be_dp.sv
// Drives two ram_be_dp configurations with identical traffic and checks them
// against a word-array reference model every cycle.
module tb_ram_be_dp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [1:0]  be = '0;
    logic [2:0]  wa = '0, ra = '0;
    logic [15:0] d = '0;

    always #5 clk = ~clk;

    // A: old-data RDW, no output reg, clears to 0. B: new-data RDW, output reg, clears to BEEF.
    ram_be_dp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYTE_WIDTH(8)) bus_a ();
    ram_be_dp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYTE_WIDTH(8)) bus_b ();

    ram_be_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RDW_MODE(0),
                .OUT_REG(0), .INIT_VALUE(16'h0000)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ram_be_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RDW_MODE(1),
                .OUT_REG(1), .INIT_VALUE(16'hBEEF)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.data = d;  assign bus_a.be = be;  assign bus_a.write_addr = wa;
    assign bus_a.we = we;   assign bus_a.read_addr = ra; assign bus_a.re = re;
    assign bus_b.data = d;  assign bus_b.be = be;  assign bus_b.write_addr = wa;
    assign bus_b.we = we;   assign bus_b.read_addr = ra; assign bus_b.re = re;

    int          n_chk = 0, n_fail = 0;
    logic [15:0] mem_a [8];
    logic [15:0] mem_b [8];
    int          busy = 0;
    logic [15:0] qa = '0, qb = '0, pdb = '0;
    logic        va = 1'b0, vb = 1'b0, pvb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nd,
                                          input logic [1:0] lanes);
        logic [15:0] r = old;
        if (lanes[0]) r[7:0]  = nd[7:0];
        if (lanes[1]) r[15:8] = nd[15:8];
        return r;
    endfunction

    // One clock cycle: present inputs, advance the model at the edge, compare 1ns later.
    task automatic step(input logic r, input logic w, input logic [1:0] b, input logic [2:0] wad,
                        input logic [15:0] dat, input logic rr, input logic [2:0] rad);
        logic        rdr, wr;
        logic [15:0] olda, newb;
        @(negedge clk);
        rst = r; we = w; be = b; wa = wad; d = dat; re = rr; ra = rad;
        @(posedge clk);
        if (r) begin
            busy = 8;
            for (int i = 0; i < 8; i++) begin mem_a[i] = 16'h0000; mem_b[i] = 16'hBEEF; end
            qa = '0; va = 1'b0; qb = '0; vb = 1'b0; pvb = 1'b0; pdb = '0;
        end else begin
            rdr  = (busy == 0) && rr;
            wr   = (busy == 0) && w;
            olda = mem_a[rad];
            newb = (wr && wad == rad) ? merge(mem_b[rad], dat, b) : mem_b[rad];
            va = rdr;
            if (rdr) qa = olda;
            vb = pvb;
            if (pvb) qb = pdb;
            pvb = rdr;
            if (rdr) pdb = newb;
            if (wr) begin
                mem_a[wad] = merge(mem_a[wad], dat, b);
                mem_b[wad] = merge(mem_b[wad], dat, b);
            end
            if (busy > 0) busy--;
        end
        #1;
        chk("a_busy",  32'(bus_a.init_busy), 32'(busy != 0));
        chk("b_busy",  32'(bus_b.init_busy), 32'(busy != 0));
        chk("a_valid", 32'(bus_a.q_valid),   32'(va));
        chk("b_valid", 32'(bus_b.q_valid),   32'(vb));
        chk("a_q",     32'(bus_a.q),         32'(qa));
        chk("b_q",     32'(bus_b.q),         32'(qb));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
    endtask

    initial begin
        // Reset and full sweep, then read every word back.
        step(1, 0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        idle(8);
        for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'(i));
        idle(2);
        // Single-lane write then read.
        step(0, 1, 2'b01, 3'd3, 16'h00A5, 0, 3'd0);
        step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'd3);
        idle(3);
        // Partial-lane update of a full word.
        step(0, 1, 2'b11, 3'd1, 16'h1234, 0, 3'd0);
        step(0, 1, 2'b01, 3'd1, 16'hFFEE, 0, 3'd0);
        step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'd1);
        idle(2);
        // be=0 write is a no-op.
        step(0, 1, 2'b00, 3'd1, 16'hDEAD, 0, 3'd0);
        step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'd1);
        idle(2);
        // Read during write to the same address.
        step(0, 1, 2'b11, 3'd5, 16'h0011, 0, 3'd0);
        step(0, 1, 2'b11, 3'd5, 16'h0022, 1, 3'd5);
        step(0, 1, 2'b10, 3'd5, 16'h3344, 1, 3'd5);
        idle(3);
        // Distinct writes then back-to-back reads.
        for (int i = 0; i < 8; i++) step(0, 1, 2'b11, 3'(i), 16'(16'h0100 * i + 16'h0007 * i + 16'h0C00), 0, 3'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'(i));
        idle(3);
        // Reset mid-sweep with writes/reads requested throughout.
        step(1, 0, 2'b00, 3'd0, 16'h0, 0, 3'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'b11, 3'd2, 16'h5A5A, 1, 3'd2);
        step(1, 1, 2'b11, 3'd2, 16'h5A5A, 1, 3'd2);
        for (int i = 0; i < 8; i++) step(0, 1, 2'b11, 3'd2, 16'h6B6B, 1, 3'd2);
        step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'd2);
        idle(3);
        // Reset while reads are in flight.
        step(0, 0, 2'b00, 3'd0, 16'h0, 1, 3'd4);
        step(1, 0, 2'b00, 3'd0, 16'h0, 1, 3'd4);
        idle(9);
        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic       r, w, rr;
            logic [2:0] wad, rad;
            r   = ($urandom_range(99) == 0);
            w   = 1'($urandom_range(1));
            rr  = ($urandom_range(3) != 0);
            wad = 3'($urandom_range(7));
            rad = ($urandom_range(3) == 0) ? wad : 3'($urandom_range(7));
            step(r, w, 2'($urandom_range(3)), wad, 16'($urandom), rr, rad);
        end
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
